// File: rtl/axa_pkg.sv
// Shared definitions for the AXA fetch stage: word widths, opcode fields, the
// NOP word, the fetch-queue entry layout and the stop-opcode decoder.
// Latency: n/a (types and constants only). Backpressure: n/a.
package axa_pkg;

    localparam int WORD_W = 16;
    localparam int INST_W = 16;

    // Opcode lives in the top six bits of every instruction word.
    localparam int OP_HI = 15;
    localparam int OP_LO = 10;
    localparam int OP_W  = OP_HI - OP_LO + 1;

    localparam logic [OP_W-1:0] OP_SYS  = 6'b111000;
    localparam logic [OP_W-1:0] OP_FAIL = 6'b110001;
    localparam logic [OP_W-1:0] OP_NOP  = 6'b111010;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [INST_W-1:0] inst_t;

    localparam inst_t NOP_WORD = {OP_NOP, 10'b0};

    // One fetch-queue entry: the word, where it came from, the PC saved at the
    // last redirect, and the direction the core was executing when it issued.
    typedef struct packed {
        inst_t ir;
        word_t pc;
        word_t lastpc;
        logic  fwd;
    } fetch_ent_t;

    localparam fetch_ent_t ENT_RESET = '{ir: NOP_WORD, pc: '0, lastpc: '0, fwd: 1'b1};

    // sys and fail both halt fetch; both opcodes carry bit 15 set, which is
    // tested explicitly so a future opcode reassignment cannot alias.
    function automatic logic is_stop(input inst_t w);
        return w[OP_HI] && ((w[OP_HI:OP_LO] == OP_SYS) || (w[OP_HI:OP_LO] == OP_FAIL));
    endfunction

endpackage

// File: rtl/axa_fetch_if.sv
// Bundle of the fetch stage's memory, control and decode-side signals.
// Latency: n/a (wiring only). Backpressure: out_valid/out_ready toward decode.
// master = fetch stage (drives imem_addr and out_*), slave = surrounding core.
interface axa_fetch_if;
    import axa_pkg::*;

    word_t imem_addr;
    inst_t imem_data;
    logic  reverse;
    logic  hold;
    logic  redirect;
    word_t redirect_target;
    logic  out_valid;
    logic  out_ready;
    inst_t out_ir;
    word_t out_pc;
    word_t out_lastpc;
    logic  out_fwd;

    modport master (
        output imem_addr,
        input  imem_data,
        input  reverse,
        input  hold,
        input  redirect,
        input  redirect_target,
        output out_valid,
        input  out_ready,
        output out_ir,
        output out_pc,
        output out_lastpc,
        output out_fwd
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output reverse,
        output hold,
        output redirect,
        output redirect_target,
        input  out_valid,
        output out_ready,
        input  out_ir,
        input  out_pc,
        input  out_lastpc,
        input  out_fwd
    );

endinterface

// File: rtl/axa_fetch_queue.sv
// Two-entry shift FIFO holding issued fetch entries; slot 0 is always the head.
// Latency: 1 cycle push to head visible. Backpressure: push ignored when full
// unless a pop happens the same cycle; pop ignored when empty; flush wins.
// Ports: clk, reset, push/push_dat, pop, flush in; full, empty, head_dat out.
module axa_fetch_queue
    import axa_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  fetch_ent_t push_dat,
    input  logic       pop,
    input  logic       flush,
    output logic       full,
    output logic       empty,
    output fetch_ent_t head_dat
);

    localparam logic [1:0] FULL_CNT = 2'(DEPTH);

    fetch_ent_t ent0_q, ent0_d;
    fetch_ent_t ent1_q, ent1_d;
    logic [1:0] count_q, count_d;
    logic       pop_ok;
    logic       push_ok;

    always_comb begin
        pop_ok  = pop && (count_q != 2'd0);
        push_ok = push && ((count_q != FULL_CNT) || pop_ok);
    end

    // Flush only clears the count: slot 0 keeps its contents so the head
    // fields seen by decode hold their last values while the queue is empty.
    // The same holds after the last entry is popped, since nothing shifts in.
    always_comb begin
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (pop_ok && (count_q == 2'd2)) begin
                ent0_d = ent1_q;
            end
            if (push_ok) begin
                if ((count_q == 2'd0) || ((count_q == 2'd1) && pop_ok)) begin
                    ent0_d = push_dat;
                end else begin
                    ent1_d = push_dat;
                end
            end
            count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ent0_q  <= ENT_RESET;
            ent1_q  <= ENT_RESET;
            count_q <= 2'd0;
        end else begin
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        full     = (count_q == FULL_CNT);
        empty    = (count_q == 2'd0);
        head_dat = ent0_q;
    end

endmodule

// File: rtl/axa_fetch.sv
// Fetch stage: walks the PC forward or backward, pushes words into a 2-deep queue,
// halts on sys/fail until redirected. Latency: 1 cycle issue to out_valid.
// Backpressure: out_ready stalls issue only once the queue is full; hold stalls issue.
// Ports: clk, reset (sync, active-high), fif (master): imem_addr/imem_data,
// reverse, hold, redirect/redirect_target, out_valid/out_ready, out_ir/pc/lastpc/fwd.
module axa_fetch
    import axa_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    axa_fetch_if.master  fif
);

    word_t      pc_q, pc_d;
    word_t      lastpc_q, lastpc_d;
    logic       stopped_q, stopped_d;

    logic       q_full;
    logic       q_empty;
    logic       pop;
    logic       issue;
    fetch_ent_t push_dat;
    fetch_ent_t head;

    // A pop in the same cycle frees a slot, so a full queue still issues
    // when decode is taking the head.
    always_comb begin
        pop      = !q_empty && fif.out_ready;
        issue    = !fif.hold && !fif.redirect && !stopped_q && (!q_full || pop);
        push_dat = '{ir: fif.imem_data, pc: pc_q, lastpc: lastpc_q, fwd: !fif.reverse};
    end

    always_comb begin
        pc_d      = pc_q;
        lastpc_d  = lastpc_q;
        stopped_d = stopped_q;
        if (fif.redirect) begin
            // lastpc records the address just behind the PC we are leaving,
            // which is what land needs to step back to the branch source.
            pc_d      = fif.redirect_target;
            lastpc_d  = pc_q - 16'd1;
            stopped_d = 1'b0;
        end else if (issue) begin
            pc_d = fif.reverse ? (pc_q - 16'd1) : (pc_q + 16'd1);
            if (is_stop(fif.imem_data)) begin
                stopped_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= '0;
            lastpc_q  <= '0;
            stopped_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            lastpc_q  <= lastpc_d;
            stopped_q <= stopped_d;
        end
    end

    axa_fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk      (clk),
        .reset    (reset),
        .push     (issue),
        .push_dat (push_dat),
        .pop      (pop),
        .flush    (fif.redirect),
        .full     (q_full),
        .empty    (q_empty),
        .head_dat (head)
    );

    // Only the instruction word is masked when empty; the address and
    // direction fields keep showing the last head.
    assign fif.imem_addr  = pc_q;
    assign fif.out_valid  = !q_empty;
    assign fif.out_ir     = q_empty ? NOP_WORD : head.ir;
    assign fif.out_pc     = head.pc;
    assign fif.out_lastpc = head.lastpc;
    assign fif.out_fwd    = head.fwd;

endmodule

// File: doc/axa_fetch.md
AXA_FETCH -- requirements
Module: axa_fetch

Interface
REQ-001 SHALL have parameter QDEPTH, default 2, giving the fetch-queue depth in entries; only the value 2 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port imem_addr, output, 16 bits: instruction memory address, equal to the current PC.
REQ-005 SHALL have port imem_data, input, 16 bits: instruction word at imem_addr, valid in the same cycle (combinational read).
REQ-006 SHALL have port reverse, input, 1 bit: 1 when the error register is non-zero, which puts the core in reverse execution.
REQ-007 SHALL have port hold, input, 1 bit: 1 when a branch is in decode or register read; no issue while asserted.
REQ-008 SHALL have port redirect, input, 1 bit: a taken branch resolved downstream.
REQ-009 SHALL have port redirect_target, input, 16 bits: the absolute next PC.
REQ-010 SHALL have port out_valid, output, 1 bit: the queue head is valid.
REQ-011 SHALL have port out_ready, input, 1 bit: decode accepts the head this cycle.
REQ-012 SHALL have port out_ir, output, 16 bits: the head instruction, or NOP {111010,10'b0} when out_valid=0.
REQ-013 SHALL have port out_pc, output, 16 bits: the fetch address of the head.
REQ-014 SHALL have port out_lastpc, output, 16 bits: the PC saved at the last redirect, used by land.
REQ-015 SHALL have port out_fwd, output, 1 bit: the execution direction captured when the head was issued.

Function
REQ-016 Issue SHALL occur in a cycle when all of the following hold: not hold, not redirect, not stopped, and either count<2 or a pop happens in the same cycle.
REQ-017 On issue, the entry {imem_data, pc, lastpc, !reverse} SHALL be pushed; pc<=pc+1 if reverse=0, else pc-1, modulo 2^16.
REQ-018 A pop SHALL occur when out_valid && out_ready; a push and a pop in the same cycle when full SHALL leave count at 2.
REQ-019 Redirect SHALL have highest priority and SHALL flush all entries (count<=0).
REQ-020 On redirect: pc<=redirect_target; lastpc<=pc-1 mod 2^16; stopped<=0; no push that cycle.
REQ-021 Entries SHALL be delivered in issue order, with latency 1 cycle from issue to out_valid.
REQ-022 Stop: issuing a word with bit15=1 and [15:10]=111000 (sys) or 110001 (fail) SHALL set stopped.
REQ-023 While stopped, no further issue SHALL occur until redirect or reset, and the queue SHALL still drain.
REQ-024 hold SHALL freeze pc and issue only; pops SHALL continue.
REQ-025 A change on reverse SHALL affect only subsequent issues; entries already queued SHALL keep their fwd bit.
REQ-026 Empty queue: out_valid=0, out_ir=NOP, and out_pc, out_lastpc and out_fwd SHALL hold their last values.
REQ-027 Count SHALL never exceed 2 and never underflow; a pop SHALL never be granted while empty.

Reset
REQ-028 On reset: pc=0, lastpc=0, count=0, stopped=0, out_valid=0, out_ir=NOP, out_pc=0, out_lastpc=0, out_fwd=1.
REQ-029 Reset SHALL override redirect, hold and handshake in the same cycle, and SHALL discard in-flight entries mid-operation.

Structure
REQ-030 A shared package axa_pkg SHALL hold WORD/INST widths, the instruction field ranges, the opcode constants (sys, fail, nop) and the NOP word.
REQ-031 The 2-entry FIFO SHALL be the sub-module axa_fetch_queue, with push, pop, flush, full and empty ports.
REQ-032 Stop detection and the PC/lastpc registers SHALL reside in axa_fetch.

Verification
REQ-033 Reset, im[0..3]=8001,8002,8003,8004, out_ready=1 -> out_pc 0,1,2,3 on consecutive cycles, out_fwd=1.
REQ-034 out_ready=0 for 3 cycles from reset -> count saturates at 2 and pc stops at 2; release -> words 0,1,2 in order, no loss or duplicates.
REQ-035 pc=5, count=2, redirect with target 0x0040 -> next cycle out_valid=0; then out_pc=0x0040, out_lastpc=4.
REQ-036 reverse=1 at pc=10 -> issued pcs 10,9,8 with out_fwd=0; pc=0 with reverse=1 -> next pc 0xFFFF.
REQ-037 im[2]=E000 (sys) -> words 0,1,2 delivered, imem_addr stays 3, no further issue until redirect.
REQ-038 hold=1 for 2 cycles with count=2, out_ready=1 -> queue drains to 0, pc unchanged; hold drop -> issue resumes at the same pc.
